result_ascii_formatter: RTL and testbench

Converts one signed 8-bit ALU result plus its overflow flag into an ASCII character stream for a byte-wide transmitter such as a UART TX or display driver. The stream is the decimal text of the result, or "OVF" when the overflow flag is set.
- Sits downstream of the processing unit, which consumes ASCII operator codes; this block produces ASCII.
- Input and output are each a valid/ready handshake; one result is handled at a time.

---
 rtl/result_ascii_formatter_pkg.sv | 49 ++++
 rtl/result_ascii_formatter_bin2bcd.sv | 58 +++++
 rtl/result_ascii_formatter.sv | 144 ++++++++++++++
 tb/tb_result_ascii_formatter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/result_ascii_formatter_pkg.sv
// Shared constants and types for the ALU result ASCII formatter.
// Holds ASCII codes, BCD sizing, the formatter state enum and the BCD digit struct.
// Build option: RESULT_ASCII_FORMATTER_CRLF_EN adds CR/LF terminator states.
package alu_ascii_pkg;

  // Magnitude width fed to the BCD converter (must hold 128) and digits produced.
  localparam int CONV_BITS = 9;
  localparam int DIGITS    = 3;

  // Operator codes understood by the upstream processing unit.
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_MUL   = 8'h2A;
  localparam logic [7:0] ASCII_DIV   = 8'h2F;
  localparam logic [7:0] ASCII_AND   = 8'h26;
  localparam logic [7:0] ASCII_OR    = 8'h7C;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_V     = 8'h56;
  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONV,
    S_SIGN,
    S_HUND,
    S_TENS,
    S_UNIT,
    S_OVF_O,
    S_OVF_V,
`ifdef RESULT_ASCII_FORMATTER_CRLF_EN
    S_OVF_F,
    S_CR,
    S_LF
`else
    S_OVF_F
`endif
  } fmt_state_t;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } bcd3_t;

endpackage

// File: rtl/result_ascii_formatter_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter (bin2bcd_seq).
// Latency: the first shift happens on the start edge, done pulses one cycle after the 9th shift edge.
// No backpressure: bcd holds its value until the next start.
// Ports: clock/reset, start (load bin), bin (magnitude), done (1-cycle pulse), bcd (H/T/U).
module bin2bcd_seq
  import alu_ascii_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CONV_BITS-1:0] bin,
  output logic                 done,
  output bcd3_t                bcd
);

  logic [CONV_BITS-1:0] sh_q;
  logic [4*DIGITS-1:0]  acc_q;
  logic [3:0]           cnt_q;
  logic                 done_q;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] a, input logic b);
    logic [4*DIGITS-1:0] t;
    t = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[4*DIGITS-2:0], b};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // The MSB is shifted in on the start edge itself, leaving CONV_BITS-1 steps.
        acc_q <= dabble('0, bin[CONV_BITS-1]);
        sh_q  <= bin << 1;
        cnt_q <= 4'(CONV_BITS - 1);
      end else if (cnt_q != 4'd0) begin
        acc_q <= dabble(acc_q, sh_q[CONV_BITS-1]);
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) done_q <= 1'b1;
      end
    end
  end

  assign done  = done_q;
  assign bcd.h = acc_q[11:8];
  assign bcd.t = acc_q[7:4];
  assign bcd.u = acc_q[3:0];

endmodule

// File: rtl/result_ascii_formatter.sv
// Formats a signed 8-bit ALU result (or "OVF") as an ASCII character stream.
// Latency: first out_valid 10 clocks after accept (normal), 1 clock after accept (overflow).
// Backpressure: out_char/out_valid are registered and held while out_ready is low; in_ready only in IDLE.
// Ports: clock, reset (async active-low), in_valid/in_ready/result_data/overflow in,
//        out_valid/out_ready/out_char out, busy = !in_ready.
// Build option: RESULT_ASCII_FORMATTER_CRLF_EN appends CR LF to every message.
module result_ascii_formatter
  import alu_ascii_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] result_data,
  input  logic       overflow,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       busy
);

  fmt_state_t           state, state_n, nxt;
  logic                 neg_q;
  logic                 accept;
  logic                 conv_start;
  logic                 conv_done;
  logic                 out_valid_n;
  logic [7:0]           out_char_n;
  logic [CONV_BITS-1:0] mag;
  bcd3_t                bcd;

  assign in_ready   = (state == S_IDLE);
  assign busy       = !in_ready;
  assign accept     = in_valid && in_ready;
  assign conv_start = accept && !overflow;
  // 8'h80 maps to 128, hence the 9-bit magnitude.
  assign mag = result_data[7] ? (9'd256 - {1'b0, result_data}) : {1'b0, result_data};

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Leading zeros are suppressed, but the units digit always prints.
  function automatic fmt_state_t first_digit(input bcd3_t b);
    fmt_state_t r;
    if (b.h != 4'd0)      r = S_HUND;
    else if (b.t != 4'd0) r = S_TENS;
    else                  r = S_UNIT;
    return r;
  endfunction

  function automatic fmt_state_t after(input fmt_state_t s, input bcd3_t b);
    fmt_state_t r;
    r = S_IDLE;
    case (s)
      S_SIGN:  r = first_digit(b);
      S_HUND:  r = S_TENS;
      S_TENS:  r = S_UNIT;
      S_OVF_O: r = S_OVF_V;
      S_OVF_V: r = S_OVF_F;
`ifdef RESULT_ASCII_FORMATTER_CRLF_EN
      S_UNIT:  r = S_CR;
      S_OVF_F: r = S_CR;
      S_CR:    r = S_LF;
`endif
      default: r = S_IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] char_of(input fmt_state_t s, input bcd3_t b);
    logic [7:0] c;
    c = 8'h00;
    case (s)
      S_SIGN:  c = ASCII_MINUS;
      S_HUND:  c = ASCII_ZERO + {4'd0, b.h};
      S_TENS:  c = ASCII_ZERO + {4'd0, b.t};
      S_UNIT:  c = ASCII_ZERO + {4'd0, b.u};
      S_OVF_O: c = ASCII_O;
      S_OVF_V: c = ASCII_V;
      S_OVF_F: c = ASCII_F;
`ifdef RESULT_ASCII_FORMATTER_CRLF_EN
      S_CR:    c = ASCII_CR;
      S_LF:    c = ASCII_LF;
`endif
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q     <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
    end else begin
      out_valid <= out_valid_n;
      out_char  <= out_char_n;
      if (accept) neg_q <= result_data[7] && !overflow;
    end
  end

  // Entering an emit state leaves out_valid low for one cycle while the
  // character is loaded; later characters load directly on each handshake
  // so out_valid stays high back to back.
  always_comb begin
    state_n     = state;
    out_valid_n = out_valid;
    out_char_n  = out_char;
    nxt         = after(state, bcd);
    case (state)
      S_IDLE: begin
        if (in_valid) state_n = overflow ? S_OVF_O : S_CONV;
      end
      S_CONV: begin
        if (conv_done) state_n = neg_q ? S_SIGN : first_digit(bcd);
      end
      default: begin
        if (!out_valid) begin
          out_valid_n = 1'b1;
          out_char_n  = char_of(state, bcd);
        end else if (out_ready) begin
          state_n = nxt;
          if (nxt == S_IDLE) begin
            out_valid_n = 1'b0;
          end else begin
            out_char_n = char_of(nxt, bcd);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_result_ascii_formatter.sv
// Self-checking bench for result_ascii_formatter: directed and random results
// compared against a text-level reference model of the expected character stream.
module tb_result_ascii_formatter;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result_data;
  logic       overflow;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       busy;

  int checks = 0;
  int errors = 0;
  byte exp_q[$];
  int  nchars;

  result_ascii_formatter dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result_data (result_data),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the decimal text of the signed value, or "OVF", plus optional CR LF.
  task automatic build_expected(input logic [7:0] d, input logic ovf);
    string s;
    exp_q.delete();
    if (ovf) s = "OVF";
    else     s = $sformatf("%0d", $signed(d));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef RESULT_ASCII_FORMATTER_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Runs one message; all interaction happens on falling edges.
  task automatic run_msg(input logic [7:0] d, input logic ovf, input int rdy_pct,
                         input bit hold_iv, input int stall_char, output int n);
    byte got_q[$];
    bit  seen;
    bit  stalled;
    logic [7:0] held;
    int  stalls;
    int  budget;
    build_expected(d, ovf);
    seen = 0; stalled = 0; held = 8'h00; stalls = 0; budget = 0;
    @(negedge clock);
    result_data = d;
    overflow    = ovf;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    while (!in_ready && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    check("ready_before_accept", in_ready, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (!hold_iv) in_valid = 1'b0;
      check("in_ready_during_msg", in_ready, 0);
      check("busy_during_msg", busy, 1);
      if (!seen && out_valid) begin
        seen = 1;
        check("first_char_latency", cyc, ovf ? 1 : 10);
      end
      if (stalled) begin
        check("held_valid", out_valid, 1);
        check("held_char", out_char, held);
      end
      if (stall_char >= 0 && out_valid && out_char == stall_char[7:0] && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      stalled = 0;
      if (out_valid && out_ready) got_q.push_back(out_char);
      else if (out_valid) begin
        stalled = 1;
        held    = out_char;
      end
      if (got_q.size() >= exp_q.size()) break;
    end
    @(negedge clock);
    check("ready_after_last", in_ready, 1);
    check("valid_gap_after_last", out_valid, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (stall_char >= 0) check("stall_cycles", stalls, 3);
    check("msg_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("char%0d_of_%0h", i, d), got_q[i], exp_q[i]);
    n = got_q.size();
  endtask

  initial begin
    bit found;
    reset       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    result_data = 8'h00;
    overflow    = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Directed values, full-rate output.
    run_msg(8'd123, 1'b0, 100, 0, -1, nchars);
    run_msg(8'h80,  1'b0, 100, 0, -1, nchars);
    run_msg(8'hFB,  1'b0, 100, 0, -1, nchars);
    run_msg(8'h00,  1'b0, 100, 0, -1, nchars);
    run_msg(8'd7,   1'b0, 100, 0, -1, nchars);
    run_msg(8'd10,  1'b0, 100, 0, -1, nchars);
    run_msg(8'h55,  1'b1, 100, 0, -1, nchars);

    // Backpressure on '2' with in_valid held high the whole time.
    run_msg(8'd123, 1'b0, 100, 1, 8'h32, nchars);

    // Reset while the tens digit of -128 is presented.
    @(negedge clock);
    result_data = 8'h80;
    overflow    = 1'b0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    found       = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clock);
      if (!in_ready) in_valid = 1'b0;
      if (out_valid && out_char == 8'h32) begin
        found = 1;
        break;
      end
    end
    check("reached_tens", found, 1);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_char", out_char, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    run_msg(8'd42, 1'b0, 100, 0, -1, nchars);

    // Message length for 99 depends on the terminator build option.
    run_msg(8'd99, 1'b0, 100, 0, -1, nchars);
`ifdef RESULT_ASCII_FORMATTER_CRLF_EN
    check("len_99", nchars, 4);
`else
    check("len_99", nchars, 2);
`endif
    run_msg(8'd99, 1'b0, 100, 1, -1, nchars);

    // Random results with random output backpressure.
    for (int k = 0; k < 25; k++) begin
      run_msg(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 70, 0, -1, nchars);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
